// File: rtl/pe_pkg.sv
// Shared constants and entry layout for the priority-encoder event FIFO.
// The timestamp field exists only when PE_EVENT_TIMESTAMP_EN is defined.
package pe_pkg;

  localparam int PE_IDX_W  = 4;
  localparam int PE_DEPTH  = 8;
  localparam int PE_DROP_W = 8;
  localparam int PE_TS_W   = 8;

`ifdef PE_EVENT_TIMESTAMP_EN
  typedef struct packed {
    logic [PE_TS_W-1:0]  ts;
    logic [PE_IDX_W-1:0] idx;
  } pe_entry_t;
`else
  typedef struct packed {
    logic [PE_IDX_W-1:0] idx;
  } pe_entry_t;
`endif

  // Width of one stored entry for a given index width.
  function automatic int pe_entry_width(input int idx_w);
`ifdef PE_EVENT_TIMESTAMP_EN
    return idx_w + PE_TS_W;
`else
    return idx_w;
`endif
  endfunction

endpackage

// File: rtl/pe_sync_fifo.sv
// Generic show-ahead synchronous FIFO.
// Pointers carry one extra wrap bit: empty when the pointers are equal,
// full when the index bits match and the wrap bits differ.
// Handshake: the caller only asserts push when !full or pop in the same
// cycle, and only asserts pop when !empty; rdata is the head, 0 when empty.
module pe_sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Advance pointers on accepted push/pop; reset empties the queue at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pe_event_fifo.sv
// Change-event queue behind the 16-input priority encoder.
// Detects a new winner or valid rising, queues the index in a show-ahead
// FIFO and drains it over out_valid/out_ready. Drops while full set a
// sticky overflow flag and bump a saturating drop counter.
// Handshake: the head transfers on a cycle with out_valid && out_ready;
// out_valid never depends on out_ready and the head holds until taken.
// Optional build macro PE_EVENT_TIMESTAMP_EN adds an 8-bit cycle counter
// stored with each entry and shown on out_ts.
module pe_event_fifo
  import pe_pkg::*;
#(
  parameter int IDX_W  = PE_IDX_W,
  parameter int DEPTH  = PE_DEPTH,
  parameter int DROP_W = PE_DROP_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [IDX_W-1:0]          in_idx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          out_idx,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_cnt,
  input  logic                      clear_ovf
`ifdef PE_EVENT_TIMESTAMP_EN
  ,
  output logic [PE_TS_W-1:0]        out_ts
`endif
);

  localparam int ENTRY_W = pe_entry_width(IDX_W);
  localparam logic [DROP_W-1:0] DROP_ONE = 1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic               last_valid;
  logic [IDX_W-1:0]   last_idx;
  logic               chg_event;
  logic               push;
  logic               pop;
  logic               drop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;

  // An event is a valid sample whose winner differs from the previous
  // cycle, or any valid sample following an invalid one.
  assign chg_event = in_valid && (!last_valid || (in_idx != last_idx));
  assign pop       = !empty && out_ready;
  assign push      = chg_event && (!full || pop);
  assign drop      = chg_event && full && !pop;

  assign out_valid = !empty;
  assign out_idx   = rdata[IDX_W-1:0];

`ifdef PE_EVENT_TIMESTAMP_EN
  logic [PE_TS_W-1:0] ts;

  // Free-running cycle counter; wraps naturally at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts <= '0;
    else     ts <= ts + 8'd1;
  end

  assign wdata  = {ts, in_idx};
  assign out_ts = rdata[ENTRY_W-1:IDX_W];
`else
  assign wdata  = in_idx;
`endif

  // Remember the previous encoder sample for change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_valid <= 1'b0;
      last_idx   <= '0;
    end else begin
      last_valid <= in_valid;
      last_idx   <= in_idx;
    end
  end

  // Sticky overflow and saturating drop count; a same-cycle drop beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_ovf)              drop_cnt <= DROP_ONE;
      else if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + DROP_ONE;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  pe_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_pe_event_fifo.sv
// Directed bench for pe_event_fifo: one task per scenario, inline checks,
// expected drain order held in exp_q.
module tb_pe_event_fifo;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_idx;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_idx;
  logic [3:0] count;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       clear_ovf;
`ifdef PE_EVENT_TIMESTAMP_EN
  logic [7:0] out_ts;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [3:0] exp_q[$];

  pe_event_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_idx    (in_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .clear_ovf (clear_ovf)
`ifdef PE_EVENT_TIMESTAMP_EN
    ,
    .out_ts    (out_ts)
`endif
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Advance one edge and settle 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_idx = '0; out_ready = 1'b0; clear_ovf = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic push_idx(input logic [3:0] idx);
    in_valid = 1'b1; in_idx = idx;
    step();
  endtask

  // Drain exp_q.size() entries, checking order and out_valid.
  task automatic drain(input string name);
    in_valid = 1'b0;
    while (exp_q.size() > 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      vec_cnt++;
      if (out_valid !== 1'b1 || out_idx !== e) begin
        err_cnt++;
        $display("FAIL %s drain: got valid=%b idx=%0d want valid=1 idx=%0d", name, out_valid, out_idx, e);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    vec_cnt++;
    if (count !== 4'd0 || out_valid !== 1'b0 || out_idx !== 4'd0) begin
      err_cnt++;
      $display("FAIL %s empty: got count=%0d valid=%b idx=%0d want 0 0 0", name, count, out_valid, out_idx);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++;
    if (out_valid !== 1'b0 || out_idx !== 4'd0 || count !== 4'd0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      err_cnt++;
      $display("FAIL reset: got v=%b idx=%0d cnt=%0d ovf=%b drop=%0d want all 0", out_valid, out_idx, count, overflow, drop_cnt);
    end
  endtask

  task automatic test_single_event();
    int seen;
    logic [3:0] first_idx;
    do_reset();
    seen = 0; first_idx = '0;
    in_valid = 1'b1; in_idx = 4'd5; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid === 1'b1) begin
        if (seen == 0) first_idx = out_idx;
        seen++;
      end
    end
    vec_cnt++;
    if (seen != 1 || first_idx !== 4'd5) begin
      err_cnt++;
      $display("FAIL single_event: got %0d cycles idx=%0d want 1 cycle idx=5", seen, first_idx);
    end
    vec_cnt++;
    if (count !== 4'd0) begin
      err_cnt++;
      $display("FAIL single_event count: got %0d want 0", count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_sequence();
    logic [3:0] seq [4];
    seq = '{4'd3, 4'd7, 4'd7, 4'd2};
    do_reset();
    for (int i = 0; i < 4; i++) push_idx(seq[i]);
    vec_cnt++;
    if (count !== 4'd3) begin
      err_cnt++;
      $display("FAIL sequence count: got %0d want 3", count);
    end
    exp_q = '{4'd3, 4'd7, 4'd2};
    drain("sequence");
  endtask

  task automatic test_revalid();
    do_reset();
    push_idx(4'd4);
    in_valid = 1'b0; step();
    push_idx(4'd4);
    vec_cnt++;
    if (count !== 4'd2) begin
      err_cnt++;
      $display("FAIL revalid count: got %0d want 2", count);
    end
    exp_q = '{4'd4, 4'd4};
    drain("revalid");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) push_idx(4'(i));
    vec_cnt++;
    if (count !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      err_cnt++;
      $display("FAIL overflow: got cnt=%0d ovf=%b drop=%0d want 8 1 2", count, overflow, drop_cnt);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(4'(i));
    drain("overflow");
    vec_cnt++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      err_cnt++;
      $display("FAIL overflow sticky: got ovf=%b drop=%0d want 1 2", overflow, drop_cnt);
    end
    clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
    vec_cnt++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      err_cnt++;
      $display("FAIL clear_ovf: got ovf=%b drop=%0d want 0 0", overflow, drop_cnt);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) push_idx(4'(i));
    in_idx = 4'd9; in_valid = 1'b1; out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    vec_cnt++;
    if (count !== 4'd8 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL full_push_pop: got cnt=%0d drop=%0d ovf=%b want 8 0 0", count, drop_cnt, overflow);
    end
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
    drain("full_push_pop");
  endtask

  task automatic test_clear_vs_drop();
    do_reset();
    for (int i = 0; i < 8; i++) push_idx(4'(i));
    push_idx(4'd10);
    push_idx(4'd11);
    clear_ovf = 1'b1;
    push_idx(4'd12);
    clear_ovf = 1'b0;
    vec_cnt++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
      err_cnt++;
      $display("FAIL clear_vs_drop: got ovf=%b drop=%0d want 1 1", overflow, drop_cnt);
    end
    // Saturation: 300 more distinct-index drops from 1 must stop at 255.
    for (int i = 0; i < 300; i++) push_idx((i % 2 == 0) ? 4'd13 : 4'd14);
    vec_cnt++;
    if (drop_cnt !== 8'd255 || count !== 4'd8) begin
      err_cnt++;
      $display("FAIL drop_saturate: got drop=%0d cnt=%0d want 255 8", drop_cnt, count);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_ready_empty();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    vec_cnt++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL ready_empty: got cnt=%0d valid=%b want 0 0", count, out_valid);
    end
    out_ready = 1'b0;
    push_idx(4'd6);
    push_idx(4'd8);
    vec_cnt++;
    if (count !== 4'd2 || out_idx !== 4'd6) begin
      err_cnt++;
      $display("FAIL ready_empty push: got cnt=%0d idx=%0d want 2 6", count, out_idx);
    end
    exp_q = '{4'd6, 4'd8};
    drain("ready_empty");
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 1; i <= 5; i++) push_idx(4'(i));
    in_valid = 1'b0;
    vec_cnt++;
    if (count !== 4'd5) begin
      err_cnt++;
      $display("FAIL async_reset pre: got cnt=%0d want 5", count);
    end
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if (out_valid !== 1'b0 || out_idx !== 4'd0 || count !== 4'd0) begin
      err_cnt++;
      $display("FAIL async_reset: got v=%b idx=%0d cnt=%0d want 0 0 0", out_valid, out_idx, count);
    end
    step();
    rst = 1'b0;
    step();
    push_idx(4'd1);
    in_valid = 1'b0;
    vec_cnt++;
    if (count !== 4'd1 || out_idx !== 4'd1) begin
      err_cnt++;
      $display("FAIL async_reset after: got cnt=%0d idx=%0d want 1 1", count, out_idx);
    end
  endtask

`ifdef PE_EVENT_TIMESTAMP_EN
  task automatic test_timestamp();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    push_idx(4'd3);
    in_valid = 1'b0;
    vec_cnt++;
    if (out_ts !== 8'd20 || out_idx !== 4'd3) begin
      err_cnt++;
      $display("FAIL timestamp: got ts=%0d idx=%0d want 20 3", out_ts, out_idx);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_event();
    test_sequence();
    test_revalid();
    test_overflow();
    test_full_push_pop();
    test_clear_vs_drop();
    test_ready_empty();
    test_async_reset();
`ifdef PE_EVENT_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
